aer_rx: RTL and testbench

// Receiving end of the input AER link. Completes the 4-phase REQ/ACK handshake

---
 rtl/aer_rx_if.sv | 39 +++
 rtl/aer_rx.sv | 129 ++++++++++++
 tb/tb_aer_rx.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aer_rx_if.sv
// Bundle of AER input link and core-side event stream signals for aer_rx.
// slave is the receiver's view; master is the view of the link driver and core.
interface aer_rx_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [ADDR_W-1:0] aerin_addr;
    logic              aerin_req;
    logic              aerin_ack;
    logic [ADDR_W-1:0] event_addr;
    logic              event_valid;
    logic              event_ready;
    logic              fifo_full;
    logic [ADDR_W-1:0] event_count;
    logic              clear_count;

    modport master (
        output aerin_addr,
        output aerin_req,
        output event_ready,
        output clear_count,
        input  aerin_ack,
        input  event_addr,
        input  event_valid,
        input  fifo_full,
        input  event_count
    );

    modport slave (
        input  aerin_addr,
        input  aerin_req,
        input  event_ready,
        input  clear_count,
        output aerin_ack,
        output event_addr,
        output event_valid,
        output fifo_full,
        output event_count
    );
endinterface

// File: rtl/aer_rx.sv
// AER link receiver: completes the 4-phase REQ/ACK handshake, buffers addresses in a
// show-ahead FIFO for the core and keeps a saturating per-image event count.
module aer_rx #(
    parameter int unsigned IMAGE_SIZE      = 256,
    parameter int unsigned IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned FIFO_BITS       = $clog2(FIFO_DEPTH)
) (
    input logic   clk,
    input logic   rst_n,
    aer_rx_if.slave bus
);
    localparam int unsigned AW = IMAGE_SIZE_BITS + 2;
    localparam int unsigned PW = FIFO_BITS + 1;
    localparam logic [PW-1:0] PtrOne   = PW'(1);
    localparam logic [AW-1:0] CountOne = AW'(1);
    localparam logic [AW-1:0] CountMax = {AW{1'b1}};

    typedef enum logic [0:0] {StIdle, StWaitLow} state_e;

    state_e        state_q, state_d;
    logic          ack_q, ack_d;
    logic          req_meta_q, req_s_q;
    logic          push, pop, empty, full;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] count_q, count_d;

    // REQ is asynchronous to clk; ADDR is bundled data and is already stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
        end else begin
            req_meta_q <= bus.aerin_req;
            req_s_q    <= req_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // A full FIFO holds off the ACK, stalling the transmitter instead of dropping.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_s_q && !full) begin
                    push    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = StWaitLow;
                end
            end
            StWaitLow: begin
                if (!req_s_q) begin
                    ack_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // Wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FIFO_BITS] != rd_ptr_q[FIFO_BITS]) &&
                   (wr_ptr_q[FIFO_BITS-1:0] == rd_ptr_q[FIFO_BITS-1:0]);
    assign pop   = !empty && bus.event_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q[FIFO_BITS-1:0]] <= bus.aerin_addr;
        end
    end

    // Clear wins over the increment but still counts a push of the same cycle.
    always_comb begin
        count_d = count_q;
        if (bus.clear_count) begin
            count_d = push ? CountOne : '0;
        end else if (push && (count_q != CountMax)) begin
            count_d = count_q + CountOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.aerin_ack   = ack_q;
    assign bus.event_addr  = mem_q[rd_ptr_q[FIFO_BITS-1:0]];
    assign bus.event_valid = !empty;
    assign bus.fifo_full   = full;
    assign bus.event_count = count_q;
endmodule

// File: tb/tb_aer_rx.sv
// Bench for aer_rx: directed handshakes against a queue-based scoreboard of the event
// stream and count, plus hand-computed latency, ordering and boundary checks.
module tb_aer_rx;
    localparam int unsigned IMAGE_SIZE = 256;
    localparam int unsigned AW         = 10;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned CNT_MAX    = 1023;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aer_rx_if #(.ADDR_W(AW)) bus ();

    aer_rx #(
        .IMAGE_SIZE(IMAGE_SIZE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard: every acknowledged handshake is exactly one accepted event.
    logic [AW-1:0] mq[$];
    logic [AW-1:0] pop_log[$];
    logic [AW-1:0] tx_addr = '0;
    int unsigned   mcount = 0;
    int unsigned   max_occ = 0;
    logic          prev_pop = 1'b0;
    logic          prev_clear = 1'b0;
    logic          prev_ack = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            mcount     = 0;
            prev_pop   = 1'b0;
            prev_clear = 1'b0;
            prev_ack   = 1'b0;
            check("rst_ack", bus.aerin_ack, 0);
            check("rst_valid", bus.event_valid, 0);
            check("rst_full", bus.fifo_full, 0);
            check("rst_addr", bus.event_addr, 0);
            check("rst_count", bus.event_count, 0);
        end else begin
            logic pushed;
            pushed = bus.aerin_ack && !prev_ack;
            if (prev_pop) begin
                pop_log.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (pushed) mq.push_back(tx_addr);
            if (prev_clear) mcount = pushed ? 1 : 0;
            else if (pushed && mcount < CNT_MAX) mcount++;
            if (mq.size() > max_occ) max_occ = mq.size();
            check("valid", bus.event_valid, mq.size() != 0);
            if (mq.size() != 0) check("head_addr", bus.event_addr, mq[0]);
            check("full", bus.fifo_full, mq.size() == DEPTH);
            check("count", bus.event_count, mcount);
            prev_pop   = (mq.size() != 0) && bus.event_ready;
            prev_clear = bus.clear_count;
            prev_ack   = bus.aerin_ack;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input logic level, output int n);
        n = 0;
        while (bus.aerin_ack !== level && n < 50) begin
            tick();
            n++;
        end
        if (bus.aerin_ack !== level) check("ack_wait_timeout", bus.aerin_ack, level);
    endtask

    task automatic send(input logic [AW-1:0] a, output int rise_lat, output int fall_lat);
        tx_addr        = a;
        bus.aerin_addr = a;
        bus.aerin_req  = 1'b1;
        wait_ack(1'b1, rise_lat);
        bus.aerin_req = 1'b0;
        wait_ack(1'b0, fall_lat);
    endtask

    task automatic send_q(input logic [AW-1:0] a);
        int r, f;
        send(a, r, f);
    endtask

    task automatic clear_cnt();
        bus.clear_count = 1'b1;
        tick();
        bus.clear_count = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int r, f, n;
        logic [AW-1:0] a;
        bus.aerin_addr  = '0;
        bus.aerin_req   = 1'b0;
        bus.event_ready = 1'b0;
        bus.clear_count = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("init_valid", bus.event_valid, 0);
        check("init_count", bus.event_count, 0);

        // 1: single handshake latency and capture
        send(10'h005, r, f);
        check("t1_rise_lat", r, 3);
        check("t1_fall_lat", f, 3);
        check("t1_valid", bus.event_valid, 1);
        check("t1_addr", bus.event_addr, 10'h005);
        check("t1_count", bus.event_count, 1);
        bus.event_ready = 1'b1;
        tick(2);

        // 2: back-to-back stream with the core always ready
        clear_cnt();
        check("t2_cleared", bus.event_count, 0);
        pop_log.delete();
        for (int i = 0; i < 8; i++) send_q(AW'(i));
        tick(3);
        check("t2_count", bus.event_count, 8);
        check("t2_npop", pop_log.size(), 8);
        for (int i = 0; i < 8 && i < pop_log.size(); i++) check("t2_order", pop_log[i], i);

        // 3: fill, stall the 9th, release with a one-cycle READY pulse
        bus.event_ready = 1'b0;
        clear_cnt();
        pop_log.delete();
        for (int i = 0; i < 8; i++) send_q(AW'(16 + i));
        check("t3_full", bus.fifo_full, 1);
        check("t3_count8", bus.event_count, 8);
        tx_addr        = AW'(24);
        bus.aerin_addr = AW'(24);
        bus.aerin_req  = 1'b1;
        tick(10);
        check("t3_stalled_ack", bus.aerin_ack, 0);
        check("t3_still_full", bus.fifo_full, 1);
        bus.event_ready = 1'b1;
        tick();
        bus.event_ready = 1'b0;
        n = 1;
        while (!bus.aerin_ack && n < 20) begin
            tick();
            n++;
        end
        check("t3_unblock_lat", n, 2);
        bus.aerin_req = 1'b0;
        wait_ack(1'b0, f);
        check("t3_count9", bus.event_count, 9);
        bus.event_ready = 1'b1;
        tick(12);
        check("t3_npop", pop_log.size(), 9);
        for (int i = 0; i < 9 && i < pop_log.size(); i++) check("t3_order", pop_log[i], 16 + i);

        // 4: start full, then stream while the core drains
        bus.event_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_q(AW'(32 + i));
        check("t4_full", bus.fifo_full, 1);
        bus.event_ready = 1'b1;
        max_occ = 0;
        pop_log.delete();
        for (int i = 0; i < 8; i++) send_q(AW'(40 + i));
        tick(5);
        check("t4_max_occ_ok", max_occ <= DEPTH, 1);
        check("t4_npop", pop_log.size(), 16);
        for (int i = 0; i < 16 && i < pop_log.size(); i++) check("t4_order", pop_log[i], 32 + i);
        check("t4_empty", bus.event_valid, 0);

        // 5: saturation at all-ones, then clear with and without a push
        clear_cnt();
        for (int i = 0; i < 1023; i++) send_q(AW'(i));
        tick(2);
        check("t5_at_max", bus.event_count, 1023);
        send_q(10'h3AA);
        tick(2);
        check("t5_saturated", bus.event_count, 1023);
        tx_addr        = AW'(7);
        bus.aerin_addr = AW'(7);
        bus.aerin_req  = 1'b1;
        tick(2);
        bus.clear_count = 1'b1;
        tick();
        bus.clear_count = 1'b0;
        check("t5_clr_push_ack", bus.aerin_ack, 1);
        check("t5_clr_push_count", bus.event_count, 1);
        bus.aerin_req = 1'b0;
        wait_ack(1'b0, f);
        tick(2);
        clear_cnt();
        check("t5_clr_only", bus.event_count, 0);

        // 6: reset during WAIT_LOW with 3 buffered events, REQ held across reset
        bus.event_ready = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) send_q(AW'(100 + i));
        a              = AW'(103);
        tx_addr        = a;
        bus.aerin_addr = a;
        bus.aerin_req  = 1'b1;
        wait_ack(1'b1, r);
        check("t6_in_wait_low", bus.aerin_ack, 1);
        rst_n = 1'b0;
        #2;
        check("t6_rst_ack", bus.aerin_ack, 0);
        check("t6_rst_valid", bus.event_valid, 0);
        check("t6_rst_count", bus.event_count, 0);
        tick(2);
        rst_n = 1'b1;
        wait_ack(1'b1, n);
        check("t6_recapture_lat", n, 3);
        check("t6_count", bus.event_count, 1);
        check("t6_addr", bus.event_addr, 103);
        bus.aerin_req = 1'b0;
        wait_ack(1'b0, f);
        tick(2);
        check("t6_single_push", bus.event_count, 1);
        check("t6_valid", bus.event_valid, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
